serial_vault: RTL and testbench

//  Parametrised serial unlock vault for the FPGA reversing challenges.
//  - A bit-serial frame is clocked in while cs is low and checked against a
//    key when cs goes high.
//  - A correct key unlocks the block, which then streams a secret out on o.
//  - New over the previous generation:
//    - width-generic key and secret;
//    - an exact frame-length check;
//    - a failed-attempt counter that forces a timed lockout;
//    - status outputs.
//  - Top-level instance per challenge, pins straight to the board header.

---
 rtl/serial_vault.sv | 104 ++++++++++
 tb/tb_serial_vault.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_vault.sv
// Bit-serial unlock vault: shifts a key in while cs is low, evaluates it on cs high,
// streams a secret once unlocked. Optional macro SERIAL_VAULT_ONESHOT_EN relocks after one read frame.
module serial_vault #(
  parameter int                    KEY_W          = 32,
  parameter logic [KEY_W-1:0]      KEY            = 32'h1337beef,
  parameter int                    SECRET_W       = 256,
  parameter logic [SECRET_W-1:0]   SECRET         = '0,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    LOCKOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic i,
  output logic o,
  output logic unlocked,
  output logic lockout
);

  localparam int CW = $clog2(KEY_W + 2);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [CW-1:0] CNT_KEY   = CW'(KEY_W);
  localparam logic [CW-1:0] CNT_MAX   = CW'(KEY_W + 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_TRIES - 1);
  localparam logic [LW-1:0] LCNT_INIT = LW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [KEY_W-1:0]    r_shift;
  logic [SECRET_W-1:0] r_secret;
  logic [CW-1:0]       r_bitcnt;
  logic [FW-1:0]       r_fails;
  logic [LW-1:0]       r_lcnt;

  logic [SECRET_W-1:0] w_secret_nxt;
  logic                w_match;

  // Shift written as a wide right shift so a one-bit secret still elaborates.
  assign w_secret_nxt = SECRET_W'({i, r_secret} >> 1);
  assign w_match      = (r_bitcnt == CNT_KEY) && (r_shift == KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_LOCKED;
      r_shift  <= '0;
      r_secret <= SECRET;
      r_bitcnt <= '0;
      r_fails  <= '0;
      r_lcnt   <= '0;
    end else if (r_state == ST_LOCKOUT) begin
      r_lcnt <= r_lcnt - LW'(1);
      if (r_lcnt == LW'(1))
        r_state <= ST_LOCKED;
    end else if (!cs) begin
      r_shift  <= {i, r_shift[KEY_W-1:1]};
      r_secret <= w_secret_nxt;
      r_bitcnt <= (r_bitcnt == CNT_MAX) ? r_bitcnt : r_bitcnt + CW'(1);
    end else begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_secret <= SECRET;
      if (r_bitcnt != '0) begin
        if (r_state == ST_LOCKED) begin
          if (w_match) begin
            r_state <= ST_UNLOCKED;
            r_fails <= '0;
          end else if (r_fails == FAIL_LAST) begin
            r_state <= ST_LOCKOUT;
            r_lcnt  <= LCNT_INIT;
            r_fails <= '0;
          end else begin
            r_fails <= r_fails + FW'(1);
          end
        end
`ifdef SERIAL_VAULT_ONESHOT_EN
        else begin
          r_state <= ST_LOCKED;
        end
`endif
      end
    end
  end

  // LOCKED echoes the key register on purpose; it is part of the puzzle.
  always_comb begin
    o = 1'b0;
    case (r_state)
      ST_UNLOCKED: o = r_secret[0];
      ST_LOCKED:   o = r_shift[0];
      default:     o = 1'b0;
    endcase
  end

  assign unlocked = (r_state == ST_UNLOCKED);
  assign lockout  = (r_state == ST_LOCKOUT);

endmodule

// File: tb/tb_serial_vault.sv
// Self-checking bench for serial_vault: frame table plus directed lockout, echo, reset and read sequences.
module tb_serial_vault;

  localparam logic [31:0]  KEY = 32'h1337beef;
  localparam logic [255:0] SEC = {32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
                                  32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89};

  logic clk, rst, cs, i;
  logic o, unlocked, lockout;

  int checks = 0;
  int errors = 0;

  serial_vault #(
    .KEY_W(32), .KEY(KEY), .SECRET_W(256), .SECRET(SEC),
    .MAX_TRIES(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .i(i),
    .o(o), .unlocked(unlocked), .lockout(lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          nbits;
    logic [63:0] bits;
    logic        exp_unl;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cs = 1'b1; i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    cs = 1'b0; i = b;
    tick();
  endtask

  task automatic cs_pulse();
    cs = 1'b1; i = 1'b0;
    tick();
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n);
    for (int j = 0; j < n; j++) send_bit(bits[j]);
    cs_pulse();
  endtask

  logic [31:0]  key_v;
  logic [255:0] sec_v;

  initial begin
    key_v = KEY;
    sec_v = SEC;
    rst = 1'b1; cs = 1'b1; i = 1'b0;

    vecs[0] = '{"good_key",   32, {32'h0, KEY},               1'b1};
    vecs[1] = '{"short_31",   31, {33'h0, KEY[30:0]},         1'b0};
    vecs[2] = '{"long_33",    33, {31'h0, KEY, 1'b1},         1'b0};
    vecs[3] = '{"flip_lsb",   32, {32'h0, KEY ^ 32'h1},       1'b0};
    vecs[4] = '{"flip_msb",   32, {32'h0, KEY ^ 32'h80000000}, 1'b0};
    vecs[5] = '{"idle_frame",  0, 64'h0,                      1'b0};

    // Reset state
    do_reset();
    chk("rst_unlocked", unlocked, 1'b0);
    chk("rst_lockout", lockout, 1'b0);
    chk("rst_o", o, 1'b0);

    // Frame table, each from reset
    foreach (vecs[v]) begin
      do_reset();
      send_frame(vecs[v].bits, vecs[v].nbits);
      chk({vecs[v].name, "_unl"}, unlocked, vecs[v].exp_unl);
      chk({vecs[v].name, "_lck"}, lockout, 1'b0);
    end

    // T1: unlock and stream the whole secret, then the bits shifted in behind it
    do_reset();
    send_frame({32'h0, KEY}, 32);
    chk("t1_unlocked", unlocked, 1'b1);
    chk("t1_o_bit0", o, sec_v[0]);
    for (int k = 1; k <= 256; k++) begin
      send_bit(k == 1);
      if (k < 256) chk($sformatf("t1_sec_bit%0d", k), o, sec_v[k]);
      else         chk("t1_tail_in", o, 1'b1);
    end

    // T2/T3: 31- and 33-bit frames count as fails, the third wrong frame locks out
    do_reset();
    send_frame({33'h0, KEY[30:0]}, 31);
    chk("t2_31_unl", unlocked, 1'b0);
    send_frame({31'h0, KEY, 1'b1}, 33);
    chk("t2_33_unl", unlocked, 1'b0);
    chk("t2_33_lck", lockout, 1'b0);
    send_frame({32'h0, ~KEY}, 32);
    chk("t3_enter_lck", lockout, 1'b1);
    chk("t3_enter_o", o, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      send_bit(key_v[n-1]);
      chk($sformatf("t3_lck_c%0d", n), lockout, (n < 16));
      if (n < 16) chk($sformatf("t3_o_c%0d", n), o, 1'b0);
    end
    cs_pulse();
    chk("t3_ignored_bits", unlocked, 1'b0);
    send_frame({32'h0, KEY}, 32);
    chk("t3_after_unl", unlocked, 1'b1);

    // T4: idle cs-high cycles do not count as attempts
    do_reset();
    send_frame({32'h0, ~KEY}, 32);
    cs = 1'b1;
    repeat (10) tick();
    send_frame({32'h0, ~KEY}, 32);
    chk("t4_idle_lck", lockout, 1'b0);
    send_frame({32'h0, ~KEY}, 32);
    chk("t4_third_lck", lockout, 1'b1);

    // T4: echo of shift[0] while LOCKED
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (29) send_bit(1'b0);
    chk("t4_echo32", o, 1'b1);
    send_bit(1'b0);
    chk("t4_echo33", o, 1'b0);
    send_bit(1'b0);
    chk("t4_echo34", o, 1'b1);

    // T5: reset mid-frame discards partial key; reset while unlocked relocks
    do_reset();
    for (int b = 0; b < 20; b++) send_bit(key_v[b]);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int b = 20; b < 32; b++) send_bit(key_v[b]);
    cs_pulse();
    chk("t5_partial_unl", unlocked, 1'b0);
    send_frame({32'h0, KEY}, 32);
    chk("t5_unl", unlocked, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_rst_unl", unlocked, 1'b0);
    chk("t5_rst_o", o, 1'b0);

    // T6: one-shot vs sticky unlock
    do_reset();
    send_frame({32'h0, KEY}, 32);
    cs_pulse();
    chk("t6_idle_keep", unlocked, 1'b1);
    repeat (8) send_bit(1'b0);
    chk("t6_read8", o, sec_v[8]);
    cs_pulse();
`ifdef SERIAL_VAULT_ONESHOT_EN
    chk("t6_oneshot", unlocked, 1'b0);
`else
    chk("t6_sticky", unlocked, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
